// File: rtl/sha256_job_ctrl.sv
// Job sequencer for the single-block SHA-256 core: loads and pads one message,
// starts the core, waits for completion and streams the 32-byte digest out.
module sha256_job_ctrl #(
    parameter int MAX_MSG_BYTES  = 55,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_msg_valid,
    input  logic [7:0] i_msg_data,
    input  logic       i_msg_last,
    output logic       o_msg_ready,
    output logic       o_dig_valid,
    output logic [7:0] o_dig_data,
    output logic       o_dig_last,
    input  logic       i_dig_ready,
    output logic       o_err,
    output logic       o_busy,
    output logic       o_core_rst_n,
    output logic [6:0] o_core_addr,
    output logic [7:0] o_core_data,
    output logic       o_core_we,
    input  logic       i_core_irq,
    input  logic [7:0] i_core_data
);

    // state  | meaning
    // IDLE   | waiting for the first message byte, core out of reset
    // CRST   | two-cycle core reset pulse (low, then high)
    // ID     | check WHO_AM_I
    // LOAD   | accept message bytes, write to core window
    // DRAIN  | discard the rest of a rejected message
    // PAD    | write 0x80, zero fill and bit length
    // START  | write STATUS=0x01
    // WAIT   | wait for core completion with timeout
    // READ   | stream digest bytes out
    typedef enum logic [3:0] {
        S_IDLE, S_CRST, S_ID, S_LOAD, S_DRAIN, S_PAD, S_START, S_WAIT, S_READ
    } state_t;

    localparam int           TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]   N_MAX     = 6'(MAX_MSG_BYTES);
    localparam logic [7:0]   WHO_AM_I  = 8'h07;
    localparam logic [6:0]   ADDR_ID   = 7'd64;
    localparam logic [6:0]   ADDR_STAT = 7'd65;
    localparam logic [6:0]   ADDR_DIG0 = 7'd101;

    state_t          state, state_nxt;
    logic [5:0]      n;          // byte index in LOAD, position in PAD, digest index in READ
    logic [5:0]      msg_len;
    logic [TW-1:0]   tmo;
    logic            dig_valid, dig_last;
    logic [7:0]      dig_data;
    logic            msg_hs, dig_hs, dig_load;
    logic            core_rst_n_int;

    assign msg_hs   = i_msg_valid && (state == S_LOAD || state == S_DRAIN);
    assign dig_hs   = dig_valid && i_dig_ready;
    assign dig_load = (state == S_READ) && (n < 6'd32) && (!dig_valid || i_dig_ready);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            n         <= '0;
            msg_len   <= '0;
            tmo       <= '0;
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            dig_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:  n <= '0;
                S_CRST:  n <= n + 6'd1;
                S_ID:    n <= '0;
                S_LOAD: begin
                    if (msg_hs) begin
                        n <= n + 6'd1;
                        if (i_msg_last) msg_len <= n + 6'd1;
                    end
                end
                S_PAD:   n <= n + 6'd1;
                S_START: tmo <= TMO_LOAD;
                S_WAIT: begin
                    n <= '0;
                    if (tmo != '0) tmo <= tmo - 1'b1;
                end
                S_READ:  if (dig_load) n <= n + 6'd1;
                default: ;
            endcase
            if (dig_load) begin
                dig_data  <= i_core_data;
                dig_valid <= 1'b1;
                dig_last  <= (n == 6'd31);
            end else if (dig_hs) begin
                dig_valid <= 1'b0;
                dig_last  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_msg_valid) state_nxt = S_CRST;
            S_CRST:  if (n != 6'd0) state_nxt = S_ID;
            S_ID:    state_nxt = (i_core_data == WHO_AM_I) ? S_LOAD : S_DRAIN;
            S_LOAD: begin
                if (msg_hs) begin
                    if (n == N_MAX)   state_nxt = i_msg_last ? S_IDLE : S_DRAIN;
                    else if (i_msg_last) state_nxt = S_PAD;
                end
            end
            S_DRAIN: if (msg_hs && i_msg_last) state_nxt = S_IDLE;
            S_PAD:   if (n == 6'd63) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_core_irq)     state_nxt = S_READ;
                else if (tmo == '0) state_nxt = S_IDLE;
            end
            S_READ:  if (dig_hs && dig_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_rst_n_int = 1'b1;
        o_core_we      = 1'b0;
        o_core_addr    = '0;
        o_core_data    = '0;
        o_msg_ready    = 1'b0;
        o_err          = 1'b0;
        case (state)
            S_CRST:  core_rst_n_int = (n != 6'd0);
            S_ID: begin
                o_core_addr = ADDR_ID;
                o_err       = (i_core_data != WHO_AM_I);
            end
            S_LOAD: begin
                o_msg_ready = 1'b1;
                if (msg_hs) begin
                    o_core_we   = 1'b1;
                    o_core_addr = 7'd63 - {1'b0, n};
                    o_core_data = i_msg_data;
                    o_err       = (n == N_MAX);
                end
            end
            S_DRAIN: o_msg_ready = 1'b1;
            S_PAD: begin
                o_core_we   = 1'b1;
                o_core_addr = 7'd63 - {1'b0, n};
                // bit length is L*8, so its high byte is L>>5 and low byte is L<<3
                if (n == msg_len)     o_core_data = 8'h80;
                else if (n == 6'd62)  o_core_data = {7'd0, msg_len[5]};
                else if (n == 6'd63)  o_core_data = {msg_len[4:0], 3'b000};
            end
            S_START: begin
                o_core_we   = 1'b1;
                o_core_addr = ADDR_STAT;
                o_core_data = 8'h01;
            end
            S_WAIT:  o_err = !i_core_irq && (tmo == '0);
            S_READ:  o_core_addr = ADDR_DIG0 - {1'b0, n};
            default: ;
        endcase
    end

    // core stays in reset for as long as the controller itself is in reset
    assign o_core_rst_n = core_rst_n_int & i_rst_n;
    assign o_busy       = (state != S_IDLE);
    assign o_dig_valid  = dig_valid;
    assign o_dig_data   = dig_data;
    assign o_dig_last   = dig_last;

endmodule

// File: tb/tb_sha256_job_ctrl.sv
// Directed bench for sha256_job_ctrl with a behavioural SHA-256 core model
// attached to the core register port.
module tb_sha256_job_ctrl;

    logic       i_clk, i_rst_n;
    logic       i_msg_valid, i_msg_last, o_msg_ready;
    logic [7:0] i_msg_data;
    logic       o_dig_valid, o_dig_last, i_dig_ready;
    logic [7:0] o_dig_data;
    logic       o_err, o_busy, o_core_rst_n, o_core_we, i_core_irq;
    logic [6:0] o_core_addr;
    logic [7:0] o_core_data, i_core_data;

    sha256_job_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_msg_valid(i_msg_valid), .i_msg_data(i_msg_data), .i_msg_last(i_msg_last),
        .o_msg_ready(o_msg_ready),
        .o_dig_valid(o_dig_valid), .o_dig_data(o_dig_data), .o_dig_last(o_dig_last),
        .i_dig_ready(i_dig_ready),
        .o_err(o_err), .o_busy(o_busy), .o_core_rst_n(o_core_rst_n),
        .o_core_addr(o_core_addr), .o_core_data(o_core_data), .o_core_we(o_core_we),
        .i_core_irq(i_core_irq), .i_core_data(i_core_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [255:0] ABC_DIG =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    function automatic logic [31:0] ror(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = 32'h6a09e667; b = 32'hbb67ae85; c = 32'h3c6ef372; d = 32'ha54ff53a;
        e = 32'h510e527f; f = 32'h9b05688c; g = 32'h1f83d9ab; h = 32'h5be0cd19;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + 32'h6a09e667, b + 32'hbb67ae85, c + 32'h3c6ef372, d + 32'ha54ff53a,
                e + 32'h510e527f, f + 32'h9b05688c, g + 32'h1f83d9ab, h + 32'h5be0cd19};
    endfunction

    // Core model: window bytes at 0..63, digest byte j at 101-j, irq a few cycles after start.
    logic [7:0] cmem [0:127];
    logic       core_irq, irq_en;
    logic [7:0] who;
    int         core_dly;

    assign i_core_irq  = core_irq;
    assign i_core_data = (o_core_addr == 7'd64) ? who : cmem[o_core_addr];

    always @(posedge i_clk) begin
        logic [511:0] cblk;
        logic [255:0] cdg;
        if (!o_core_rst_n) begin
            core_irq <= 1'b0;
            core_dly <= 0;
        end else begin
            if (o_core_we) begin
                if (o_core_addr == 7'd65 && o_core_data == 8'h01) core_dly <= 5;
                else if (o_core_addr < 7'd64) cmem[o_core_addr] <= o_core_data;
            end
            if (core_dly == 1) begin
                for (int k = 0; k < 64; k++) cblk[511 - 8*k -: 8] = cmem[63 - k];
                cdg = sha256_blk(cblk);
                for (int j = 0; j < 32; j++) cmem[101 - j] <= cdg[255 - 8*j -: 8];
                core_irq <= irq_en;
            end
            if (core_dly != 0) core_dly <= core_dly - 1;
        end
    end

    int           n_tests, n_fail;
    int           cyc, err_cnt, err_cyc, start_cyc, crst_cnt, dv_cnt, stall_bad, stall_cnt;
    int           ndig, nsent, last_hs_cyc;
    int           wr_cnt [0:127];
    logic [7:0]   wr_val [0:127];
    logic [7:0]   msg_buf [0:63];
    logic [255:0] dig_vec, d1;
    logic [31:0]  last_bits;
    logic         s_msg_hs, prev_stall, rdy_mode;
    logic [7:0]   prev_data;
    logic [3:0]   rdy_pat;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_block(input int len);
        logic [511:0] blk = '0;
        for (int k = 0; k < len; k++) blk[511 - 8*k -: 8] = msg_buf[k];
        blk[511 - 8*len -: 8] = 8'h80;
        blk[15:0] = 16'(len * 8);
        return blk;
    endfunction

    function automatic int write_errs(input int len);
        logic [511:0] blk = exp_block(len);
        int bad = 0;
        for (int a = 0; a < 64; a++)
            if (wr_cnt[a] != 1 || wr_val[a] !== blk[511 - 8*(63 - a) -: 8]) bad++;
        return bad;
    endfunction

    // One clock: drive sink ready, sample everything at the falling edge, return #1 after rise.
    task automatic tick();
        if (rdy_mode) i_dig_ready = rdy_pat[cyc % 4];
        @(negedge i_clk);
        cyc++;
        if (o_core_we) begin
            wr_cnt[o_core_addr]++;
            wr_val[o_core_addr] = o_core_data;
            if (o_core_addr == 7'd65) start_cyc = cyc;
        end
        if (o_err) begin err_cnt++; err_cyc = cyc; end
        if (!o_core_rst_n && i_rst_n) crst_cnt++;
        if (o_dig_valid) dv_cnt++;
        if (prev_stall && (o_dig_valid !== 1'b1 || o_dig_data !== prev_data)) stall_bad++;
        prev_stall = o_dig_valid && !i_dig_ready;
        if (prev_stall) stall_cnt++;
        prev_data = o_dig_data;
        if (o_dig_valid && i_dig_ready) begin
            if (ndig < 32) begin
                dig_vec[255 - 8*ndig -: 8] = o_dig_data;
                last_bits[ndig] = o_dig_last;
            end
            ndig++;
        end
        s_msg_hs = i_msg_valid && o_msg_ready;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int a = 0; a < 128; a++) begin wr_cnt[a] = 0; wr_val[a] = 8'h00; end
        err_cnt = 0; err_cyc = -1; start_cyc = -1; crst_cnt = 0; dv_cnt = 0;
        stall_bad = 0; stall_cnt = 0; ndig = 0; nsent = 0; dig_vec = '0; last_bits = '0;
        prev_stall = 1'b0;
    endtask

    task automatic send_msg(input int len);
        int w;
        for (int k = 0; k < len; k++) begin
            i_msg_valid = 1'b1;
            i_msg_data  = msg_buf[k];
            i_msg_last  = (k == len - 1);
            w = 0;
            do begin tick(); w++; end while (!s_msg_hs && w < 100);
            if (!s_msg_hs) break;
            nsent++;
            last_hs_cyc = cyc;
        end
        i_msg_valid = 1'b0;
        i_msg_last  = 1'b0;
        i_msg_data  = 8'h00;
    endtask

    task automatic run_job(input int len);
        clear_logs();
        send_msg(len);
        for (int c = 0; c < 600 && ndig < 32; c++) tick();
        repeat (3) tick();
    endtask

    task automatic set_abc();
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_hs_cyc = -1;
        i_rst_n = 1'b0; i_msg_valid = 1'b0; i_msg_data = 8'h00; i_msg_last = 1'b0;
        i_dig_ready = 1'b1; rdy_mode = 1'b0; rdy_pat = 4'b1001;
        irq_en = 1'b1; who = 8'h07; prev_data = 8'h00;
        for (int a = 0; a < 64; a++) msg_buf[a] = 8'h00;
        clear_logs();
        repeat (3) tick();
        chk("rst_outputs", {o_core_rst_n, o_core_we, o_core_addr, o_core_data, o_msg_ready,
                            o_dig_valid, o_dig_last, o_err, o_busy}, 0);
        i_rst_n = 1'b1;
        tick();
        chk("idle_core_rst_n", o_core_rst_n, 1);
        chk("idle_busy", o_busy, 0);

        set_abc();
        run_job(3);
        chk("abc_accepted", nsent, 3);
        chk("abc_a63", wr_val[63], 'h61);
        chk("abc_a61", wr_val[61], 'h63);
        chk("abc_a60", wr_val[60], 'h80);
        chk("abc_a0", wr_val[0], 'h18);
        chk("abc_writes", write_errs(3), 0);
        chk("abc_start", {wr_cnt[65], wr_val[65]}, {32'd1, 8'h01});
        chk("abc_crst", crst_cnt, 1);
        chk("abc_ndig", ndig, 32);
        chk_dig("abc_digest", dig_vec, ABC_DIG);
        chk("abc_last", last_bits, 32'h8000_0000);
        chk("abc_err", err_cnt, 0);
        chk("abc_idle", o_busy, 0);

        for (int k = 0; k < 55; k++) msg_buf[k] = 8'h00;
        run_job(55);
        chk("z55_a8", wr_val[8], 'h80);
        chk("z55_a1", wr_val[1], 'h01);
        chk("z55_a0", wr_val[0], 'hb8);
        chk("z55_writes", write_errs(55), 0);
        chk_dig("z55_digest", dig_vec, sha256_blk(exp_block(55)));
        chk("z55_ndig", ndig, 32);

        for (int k = 0; k < 56; k++) msg_buf[k] = 8'h5a;
        clear_logs();
        send_msg(56);
        repeat (5) tick();
        chk("ovl_accepted", nsent, 56);
        chk("ovl_err", err_cnt, 1);
        chk("ovl_err_when", err_cyc, last_hs_cyc);
        chk("ovl_no_start", wr_cnt[65], 0);
        chk("ovl_no_dig", dv_cnt, 0);
        chk("ovl_idle", o_busy, 0);

        set_abc();
        run_job(3);
        d1 = dig_vec;
        chk("b2b_crst1", crst_cnt, 1);
        run_job(3);
        chk("b2b_crst2", crst_cnt, 1);
        chk_dig("b2b_same", dig_vec, d1);
        chk_dig("b2b_digest", dig_vec, ABC_DIG);

        rdy_mode = 1'b1;
        run_job(3);
        rdy_mode = 1'b0;
        i_dig_ready = 1'b1;
        chk("tog_stable", stall_bad, 0);
        chk("tog_stalled", stall_cnt > 0, 1);
        chk("tog_ndig", ndig, 32);
        chk_dig("tog_digest", dig_vec, ABC_DIG);

        irq_en = 1'b0;
        clear_logs();
        send_msg(3);
        for (int c = 0; c < 200 && err_cnt == 0; c++) tick();
        tick();
        chk("tmo_err", err_cnt, 1);
        chk("tmo_latency", err_cyc - start_cyc, 63);
        chk("tmo_no_dig", dv_cnt, 0);
        chk("tmo_idle", o_busy, 0);
        irq_en = 1'b1;

        who = 8'h05;
        clear_logs();
        send_msg(3);
        repeat (3) tick();
        begin
            int tot = 0;
            for (int a = 0; a < 128; a++) tot += wr_cnt[a];
            chk("id_no_writes", tot, 0);
        end
        chk("id_err", err_cnt, 1);
        chk("id_accepted", nsent, 3);
        chk("id_idle", o_busy, 0);
        who = 8'h07;

        set_abc();
        clear_logs();
        send_msg(3);
        repeat (4) tick();
        chk("pad_active", {o_core_we, o_busy}, 2'b11);
        i_rst_n = 1'b0;
        tick();
        chk("midpad_outputs", {o_core_rst_n, o_core_we, o_core_addr, o_core_data, o_msg_ready,
                               o_dig_valid, o_dig_last, o_err, o_busy}, 0);
        tick();
        i_rst_n = 1'b1;
        repeat (2) tick();
        chk("midpad_quiet", {err_cnt, dv_cnt}, 0);
        run_job(3);
        chk("post_rst_writes", write_errs(3), 0);
        chk_dig("post_rst_digest", dig_vec, ABC_DIG);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_job_ctrl.md
Name: sha256_job_ctrl

Overview:
- Host-side sequencer for the single-block SHA-256 core: accepts a 1..55-byte message as a byte stream, writes it into the core's 64-byte word window, and appends FIPS 180-4 padding and length.
- Starts the core, waits for its completion flag, reads the 32-byte digest back and streams it out.
- Pulses the core reset before every job, because the core does not reload its hash variables on its own between jobs.

Parameters:
- MAX_MSG_BYTES, 55, largest message that fits one padded block; fixed by the padding rule, not tunable upward.
- TIMEOUT_CYCLES, 63, cycles allowed in WAIT for i_core_irq before an error is raised.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. The block has one clock, i_clk; reset i_rst_n is synchronous and active-low.
- i_msg_valid  in  1  message byte valid.
- i_msg_data  in  8  message byte, first byte of the message first.
- i_msg_last  in  1  marks the final message byte.
- o_msg_ready  out  1  controller accepts a message byte.
- o_dig_valid  out  1  digest byte valid.
- o_dig_data  out  8  digest byte, most significant byte of H0 first.
- o_dig_last  out  1  marks the 32nd digest byte.
- i_dig_ready  in  1  sink accepts a digest byte.
- o_err  out  1  one-cycle pulse: overlength message, wrong core ID, or timeout.
- o_busy  out  1  high in every state except IDLE.
- o_core_rst_n  out  1  core reset, active-low.
- o_core_addr  out  7  core register address.
- o_core_data  out  8  core write data.
- o_core_we  out  1  core write enable.
- i_core_irq  in  1  core completed flag.
- i_core_data  in  8  core combinational read mux.

Behaviour:
- Reset values: state IDLE; o_core_rst_n=0; o_core_we=0; o_core_addr=0; o_core_data=0; o_msg_ready, o_dig_valid, o_dig_last, o_err, o_busy all 0; byte counter n=0.
- Reset mid-operation aborts the job. No digest and no error are emitted. The core is held in reset while i_rst_n=0.
- Core map:
  - message byte k goes to address 63-k;
  - WHO_AM_I is at address 64 and reads 0x07;
  - STATUS is at address 65; writing 0x01 starts the core;
  - digest byte j is read from address 101-j.
- IDLE: o_core_rst_n=1. Move to CRST when i_msg_valid=1. No byte is consumed in IDLE.
- CRST: two cycles. First cycle o_core_rst_n=0, second cycle o_core_rst_n=1. Then go to ID.
- ID: o_core_addr=64. Sample i_core_data in the same cycle.
  - 0x07: go to LOAD with n=0.
  - Otherwise: pulse o_err, go to DRAIN.
- LOAD: o_msg_ready=1.
  - On each handshake: o_core_we=1, o_core_addr=63-n, o_core_data=i_msg_data, same cycle; n increments.
  - A handshake with i_msg_last and n+1<=55: latch L=n+1, go to PAD.
  - A handshake with n=55 and i_msg_last=0: pulse o_err, go to DRAIN.
- DRAIN: o_msg_ready=1, no core writes. Consume bytes until the i_msg_last handshake, then go to IDLE. If i_msg_last was already consumed, go straight to IDLE.
- PAD: one write per cycle, for message positions p=L..63 in ascending order, at address 63-p.
  - Position L: data 0x80.
  - Position 62: data (L*8)>>8.
  - Position 63: data (L*8)&0xFF.
  - All other positions: data 0x00.
  - Total 64-L write cycles, then go to START.
- START: one cycle, o_core_we=1, o_core_addr=65, o_core_data=0x01. Clear the timeout counter. Go to WAIT.
- WAIT: no writes.
  - i_core_irq=1: go to READ with j=0.
  - Counter reaches TIMEOUT_CYCLES: pulse o_err, go to IDLE.
- READ: o_core_addr=101-j.
  - When the output register is empty, or is handshaking this cycle, load o_dig_data=i_core_data and set o_dig_valid=1.
  - o_dig_last=1 when j=31.
  - o_dig_data and o_dig_valid are held stable while i_dig_ready=0.
  - Throughput is one byte per cycle under continuous ready.
  - After the j=31 handshake: o_dig_valid=0, go to IDLE.
- o_err is never asserted in the same job as o_dig_valid.
- Core reset happens only in CRST. The next job's CRST always precedes reuse of the core.

Test Plan:
- "abc" (0x61 0x62 0x63, last on 0x63), core model is the real core:
  - writes: addr63=61, 62=62, 61=63, 60=80, 1=00, 0=18, all other addresses 00;
  - then a write of 01 to addr 65;
  - digest stream ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, o_dig_last on 0xad.
- 55-byte message of 0x00: addr8=80, addr1=01, addr0=B8. Digest matches the software model.
- 56-byte message: o_err pulses after byte 56. All bytes are consumed through last. No write to addr 65, no o_dig_valid.
- "abc" twice back to back: CRST observed before each job; both digests are identical.
- i_dig_ready toggling 1,0,0,1: data stable while stalled, exactly 32 handshakes. i_core_irq tied 0: o_err at START+63 cycles, then IDLE.
- i_rst_n low mid-PAD: next cycle all outputs at reset values. The following job completes correctly.
